// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: incoming VGA stream and the timing information recovered from it.
interface vga_sync_decoder_if;
    logic        pix_en;
    logic        HSync;
    logic        VSync;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        de;
    logic [23:0] rgb_out;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [10:0] h_total_meas;
    logic [9:0]  v_total_meas;
    modport master (
        output pix_en, HSync, VSync, Red, Green, Blue,
        input  pix_x, pix_y, de, rgb_out, frame_start, locked, sync_err, h_total_meas, v_total_meas
    );
    modport slave (
        input  pix_en, HSync, VSync, Red, Green, Blue,
        output pix_x, pix_y, de, rgb_out, frame_start, locked, sync_err, h_total_meas, v_total_meas
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, data-enable and timing lock from a VGA stream.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input logic               clk,
    input logic               rst_n,
    vga_sync_decoder_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
    localparam int              GW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]   GOOD_MAX = GW'(LOCK_FRAMES);
    localparam logic [11:0]     H_LEN    = 12'(H_TOTAL);
    localparam logic [10:0]     V_LEN    = 11'(V_TOTAL);
    localparam logic [10:0]     H_LO     = 11'(H_SYNC + H_BP);
    localparam logic [10:0]     H_HI     = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]      V_LO     = 10'(V_SYNC + V_BP);
    localparam logic [9:0]      V_HI     = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    state_t        state, state_d;
    logic [GW-1:0] good, good_d;
    logic          hs_q, vs_line, line_bad;
    logic [10:0]   h_cnt, h_cnt_d;
    logic [9:0]    v_cnt, v_cnt_d;
    logic          hs_rise, fs, line_ok, frame_ok, timeout, err, active;
    // Next-count values describe the sample being taken now, giving one tick of output latency.
    always_comb begin
        hs_rise  = bus.HSync & ~hs_q;
        fs       = hs_rise & bus.VSync & ~vs_line;
        line_ok  = ({1'b0, h_cnt} + 12'd1) == H_LEN;
        frame_ok = ~line_bad & line_ok & (({1'b0, v_cnt} + 11'd1) == V_LEN);
        timeout  = ~hs_rise & (h_cnt == 11'd2046);
        h_cnt_d  = hs_rise ? 11'd0 : h_cnt + {10'd0, h_cnt != 11'h7ff};
        v_cnt_d  = fs ? 10'd0 : hs_rise ? v_cnt + {9'd0, v_cnt != 10'h3ff} : v_cnt;
        state_d  = state;
        good_d   = good;
        err      = timeout;
        case (state)
            SEARCH: begin
                if (fs) begin
                    state_d = CHECK;
                    good_d  = '0;
                end
            end
            CHECK: begin
                if (fs) begin
                    good_d  = frame_ok ? good + GW'(1) : '0;
                    state_d = (frame_ok && good_d == GOOD_MAX) ? LOCKED : CHECK;
                end
            end
            LOCKED: begin
                if ((hs_rise && !line_ok) || (fs && !frame_ok)) begin
                    err     = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
        if (timeout) state_d = SEARCH;
        active = (state_d == LOCKED) && h_cnt_d >= H_LO && h_cnt_d <= H_HI && v_cnt_d >= V_LO && v_cnt_d <= V_HI;
    end
    assign bus.locked = (state == LOCKED);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= SEARCH;
            good             <= '0;
            hs_q             <= 1'b0;
            vs_line          <= 1'b0;
            line_bad         <= 1'b0;
            h_cnt            <= 11'h7ff;
            v_cnt            <= 10'h3ff;
            bus.h_total_meas <= '0;
            bus.v_total_meas <= '0;
            bus.frame_start  <= 1'b0;
            bus.sync_err     <= 1'b0;
            bus.de           <= 1'b0;
            bus.pix_x        <= '0;
            bus.pix_y        <= '0;
            bus.rgb_out      <= '0;
        end else if (bus.pix_en) begin
            state           <= state_d;
            good            <= good_d;
            hs_q            <= bus.HSync;
            h_cnt           <= h_cnt_d;
            v_cnt           <= v_cnt_d;
            if (hs_rise) vs_line <= bus.VSync;
            if (hs_rise && h_cnt != 11'h7ff) bus.h_total_meas <= h_cnt + 11'd1;
            if (fs) bus.v_total_meas <= v_cnt + 10'd1;
            line_bad        <= fs ? 1'b0 : line_bad | (hs_rise & ~line_ok);
            bus.frame_start <= fs;
            bus.sync_err    <= err;
            bus.de          <= active;
            bus.pix_x       <= active ? 10'(h_cnt_d - H_LO) : '0;
            bus.pix_y       <= active ? 9'(v_cnt_d - V_LO) : '0;
            bus.rgb_out     <= active ? {bus.Red, bus.Green, bus.Blue} : '0;
        end else begin
            bus.frame_start <= 1'b0;
            bus.sync_err    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed scenarios on a scaled-down VGA timing so whole frames fit in a short run.
module tb_vga_sync_decoder;
    localparam int HS = 4, HB = 4, HA = 16, HT = 28;
    localparam int VS = 2, VB = 2, VA = 6, VT = 12;
    localparam int HL = HS + HB, VL = VS + VB;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    vga_sync_decoder_if bus();
    vga_sync_decoder #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [67:0] outs;
    assign outs = {bus.pix_x, bus.pix_y, bus.de, bus.rgb_out, bus.frame_start, bus.locked,
                   bus.sync_err, bus.h_total_meas, bus.v_total_meas};
    int vectors = 0, miscompares = 0;
    int n_fs, n_err, n_de, n_dbad, n_leak, n_extra, tick_no = 0, err_tick;
    logic [9:0]  first_x, last_x;
    logic [8:0]  first_y, last_y;
    logic        prev_locked = 1'b0, lock_at_fs, err_locked;
    logic [10:0] err_htm;

    task automatic clear_counts();
        n_fs = 0; n_err = 0; n_de = 0; n_dbad = 0; n_leak = 0; lock_at_fs = 1'b0;
        err_tick = -1; err_htm = '0; err_locked = 1'b1;
        first_x = '1; first_y = '1; last_x = '1; last_y = '1;
    endtask

    // One pixel tick: pix_en high for one clk, outputs sampled just after that edge.
    task automatic tick(input int h, input int v, input logic hs, input logic vs);
        logic [23:0] pat;
        pat = {h[7:0], v[7:0], 8'h5A};
        bus.HSync = hs; bus.VSync = vs;
        {bus.Red, bus.Green, bus.Blue} = pat;
        bus.pix_en = 1'b1;
        tick_no++;
        @(posedge clk); #1;
        bus.pix_en = 1'b0;
        if (bus.frame_start) n_fs++;
        if (bus.sync_err) begin
            n_err++; err_tick = tick_no; err_htm = bus.h_total_meas; err_locked = bus.locked;
        end
        if (bus.locked && !prev_locked) lock_at_fs = bus.frame_start;
        prev_locked = bus.locked;
        if (bus.de) begin
            if (n_de == 0) begin first_x = bus.pix_x; first_y = bus.pix_y; end
            last_x = bus.pix_x; last_y = bus.pix_y;
            n_de++;
            if (bus.rgb_out !== pat || int'(bus.pix_x) !== h - HL || int'(bus.pix_y) !== v - VL) n_dbad++;
        end else if (bus.rgb_out !== 24'h0 || bus.pix_x !== 10'h0 || bus.pix_y !== 9'h0) n_leak++;
        @(posedge clk); #1;
        if (bus.frame_start || bus.sync_err) n_extra++;
    endtask

    task automatic send_frame(input int lines, input int bad_line, input int bad_len);
        for (int v = 0; v < lines; v++)
            for (int h = 0; h < ((v == bad_line) ? bad_len : HT); h++)
                tick(h, v, h < HS, v < VS);
    endtask

    task automatic test_reset();
        bus.pix_en = 1'b0; bus.HSync = 1'b0; bus.VSync = 1'b0;
        bus.Red = 8'h0; bus.Green = 8'h0; bus.Blue = 8'h0;
        n_extra = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (outs !== 68'h0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst_n = 1'b1; prev_locked = 1'b0;
    endtask

    task automatic test_nominal();
        clear_counts();
        send_frame(VT, -1, 0);
        send_frame(VT, -1, 0);
        vectors++;
        if (n_fs != 2 || bus.locked !== 1'b0 || n_de != 0) begin
            miscompares++; $display("FAIL pre_lock: fs=%0d locked=%b de=%0d want fs=2 locked=0 de=0", n_fs, bus.locked, n_de);
        end
        clear_counts();
        send_frame(VT, -1, 0);
        vectors++;
        if (lock_at_fs !== 1'b1 || bus.locked !== 1'b1 || n_fs != 1) begin
            miscompares++; $display("FAIL lock_on_third_fs: lock_at_fs=%b locked=%b fs=%0d want 1 1 1", lock_at_fs, bus.locked, n_fs);
        end
        vectors++;
        if (n_de != HA * VA || n_dbad != 0 || n_leak != 0) begin
            miscompares++; $display("FAIL nominal_de: de=%0d bad=%0d leak=%0d want %0d 0 0", n_de, n_dbad, n_leak, HA * VA);
        end
        vectors++;
        if (first_x !== 10'd0 || first_y !== 9'd0 || int'(last_x) !== HA - 1 || int'(last_y) !== VA - 1) begin
            miscompares++; $display("FAIL de_corners: first=(%0d,%0d) last=(%0d,%0d) want (0,0) (%0d,%0d)", first_x, first_y, last_x, last_y, HA - 1, VA - 1);
        end
        vectors++;
        if (int'(bus.h_total_meas) !== HT || int'(bus.v_total_meas) !== VT || n_err != 0) begin
            miscompares++; $display("FAIL nominal_meas: h=%0d v=%0d err=%0d want %0d %0d 0", bus.h_total_meas, bus.v_total_meas, n_err, HT, VT);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_frame(VT, -1, 0);
        vectors++;
        if (n_fs != 1 || n_err != 0 || n_de != HA * VA || n_dbad != 0 || bus.locked !== 1'b1) begin
            miscompares++; $display("FAIL back_to_back: fs=%0d err=%0d de=%0d bad=%0d locked=%b want 1 0 %0d 0 1", n_fs, n_err, n_de, n_dbad, bus.locked, HA * VA);
        end
    endtask

    task automatic test_line_fault();
        clear_counts();
        send_frame(VT, 5, HT - 1);
        vectors++;
        if (n_err != 1 || int'(err_htm) !== HT - 1 || err_locked !== 1'b0) begin
            miscompares++; $display("FAIL line_fault_err: err=%0d htm=%0d locked=%b want 1 %0d 0", n_err, err_htm, err_locked, HT - 1);
        end
        vectors++;
        if (n_de != 2 * HA || bus.locked !== 1'b0) begin
            miscompares++; $display("FAIL line_fault_de: de=%0d locked=%b want %0d 0", n_de, bus.locked, 2 * HA);
        end
        clear_counts();
        send_frame(VT, -1, 0);
        send_frame(VT, -1, 0);
        vectors++;
        if (bus.locked !== 1'b0 || n_de != 0) begin
            miscompares++; $display("FAIL line_fault_early_lock: locked=%b de=%0d want 0 0", bus.locked, n_de);
        end
        clear_counts();
        send_frame(VT, -1, 0);
        vectors++;
        if (lock_at_fs !== 1'b1 || n_de != HA * VA || n_err != 0) begin
            miscompares++; $display("FAIL line_fault_relock: lock_at_fs=%b de=%0d err=%0d want 1 %0d 0", lock_at_fs, n_de, n_err, HA * VA);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i <= 5 * HT + 10; i++) tick(i % HT, i / HT, (i % HT) < HS, (i / HT) < VS);
        vectors++;
        if (bus.de !== 1'b1 || bus.locked !== 1'b1) begin
            miscompares++; $display("FAIL pre_reset_active: de=%b locked=%b want 1 1", bus.de, bus.locked);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== 68'h0) begin miscompares++; $display("FAIL async_reset: got %h want 0", outs); end
        @(posedge clk); #1;
        rst_n = 1'b1; prev_locked = 1'b0;
    endtask

    task automatic test_frame_fault();
        clear_counts();
        send_frame(VT, -1, 0);
        send_frame(VT - 1, -1, 0);
        send_frame(VT, -1, 0);
        vectors++;
        if (int'(bus.v_total_meas) !== VT - 1) begin
            miscompares++; $display("FAIL short_frame_meas: got %0d want %0d", bus.v_total_meas, VT - 1);
        end
        send_frame(VT, -1, 0);
        vectors++;
        if (n_fs != 4 || bus.locked !== 1'b0 || n_de != 0 || n_err != 0) begin
            miscompares++; $display("FAIL frame_fault_hold: fs=%0d locked=%b de=%0d err=%0d want 4 0 0 0", n_fs, bus.locked, n_de, n_err);
        end
        clear_counts();
        send_frame(VT, -1, 0);
        vectors++;
        if (lock_at_fs !== 1'b1 || n_de != HA * VA || int'(bus.v_total_meas) !== VT) begin
            miscompares++; $display("FAIL frame_fault_relock: lock_at_fs=%b de=%0d v=%0d want 1 %0d %0d", lock_at_fs, n_de, bus.v_total_meas, HA * VA, VT);
        end
    endtask

    task automatic test_hsync_stuck();
        int s0;
        clear_counts();
        s0 = tick_no;
        repeat (2100) tick(0, 0, 1'b0, 1'b0);
        vectors++;
        if (n_err != 1 || err_tick != s0 + 2020) begin
            miscompares++; $display("FAIL stuck_err: count=%0d at=%0d want 1 at %0d", n_err, err_tick - s0, 2020);
        end
        vectors++;
        if (bus.locked !== 1'b0 || n_de != 0 || bus.de !== 1'b0) begin
            miscompares++; $display("FAIL stuck_state: locked=%b de=%0d want 0 0", bus.locked, n_de);
        end
        clear_counts();
        tick(0, 0, 1'b1, 1'b1);
        vectors++;
        if (int'(bus.h_total_meas) !== HT || n_fs != 1) begin
            miscompares++; $display("FAIL stuck_resume: htm=%0d fs=%0d want %0d 1", bus.h_total_meas, n_fs, HT);
        end
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++)
                if (v != 0 || h != 0) tick(h, v, h < HS, v < VS);
    endtask

    task automatic test_pix_en_gap();
        logic [67:0] snap;
        int chg;
        send_frame(VT, -1, 0);
        clear_counts();
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                if (v == 5 && h == 13) begin
                    snap = outs; chg = 0;
                    repeat (50) begin @(posedge clk); #1; if (outs !== snap) chg++; end
                    vectors++;
                    if (chg != 0 || bus.pix_x !== 10'd4 || bus.de !== 1'b1) begin
                        miscompares++; $display("FAIL gap_hold: changes=%0d pix_x=%0d de=%b want 0 4 1", chg, bus.pix_x, bus.de);
                    end
                end
                tick(h, v, h < HS, v < VS);
                if (v == 5 && h == 13) begin
                    vectors++;
                    if (bus.pix_x !== 10'd5 || bus.de !== 1'b1) begin
                        miscompares++; $display("FAIL gap_resume: pix_x=%0d de=%b want 5 1", bus.pix_x, bus.de);
                    end
                end
            end
        vectors++;
        if (n_de != HA * VA || n_dbad != 0 || n_leak != 0 || bus.locked !== 1'b1) begin
            miscompares++; $display("FAIL gap_frame: de=%0d bad=%0d leak=%0d locked=%b want %0d 0 0 1", n_de, n_dbad, n_leak, bus.locked, HA * VA);
        end
        vectors++;
        if (n_extra != 0) begin miscompares++; $display("FAIL pulse_width: long pulses=%0d want 0", n_extra); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_line_fault();
        test_async_reset();
        test_frame_fault();
        test_hsync_stuck();
        test_pix_en_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
